// File: rtl/regset_pkg.sv
// rtl/regset_pkg.sv - shared op and FSM state types for the register-set arbiter
package regset_pkg;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_TURN = 2'd2,
      ST_DRV  = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way arbiter; round-robin with REGSET_ARB_ROUNDROBIN_EN, else fixed priority to requester 0
module rr_arb2 (
`ifdef REGSET_ARB_ROUNDROBIN_EN
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       advance,
`endif
   input  logic [1:0] req,
   output logic       win
);

`ifdef REGSET_ARB_ROUNDROBIN_EN
   // prio names the requester that wins a tie; it flips away from each winner
   logic prio;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         prio <= 1'b0;
      end else if (advance) begin
         prio <= ~win;
      end
   end

   assign win = (req == 2'b11) ? prio : req[1];
`else
   assign win = req[1] & ~req[0];
`endif

endmodule

// File: rtl/regset_arb.sv
// rtl/regset_arb.sv - serializes two requesters onto a two-register set; arbitration mode set by REGSET_ARB_ROUNDROBIN_EN
module regset_arb (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_req_0,
   input  logic       i_op_0,
   input  logic       i_reg_0,
   input  logic [7:0] i_wdata_0,
   output logic       o_gnt_0,
   input  logic       i_req_1,
   input  logic       i_op_1,
   input  logic       i_reg_1,
   input  logic [7:0] i_wdata_1,
   output logic       o_gnt_1,
   output logic [7:0] o_d,
   output logic       o_write0,
   output logic       o_write1,
   output logic       o_busSel,
   output logic       o_busEn,
   output logic       o_busy,
   output logic       o_owner
);
   import regset_pkg::*;

   state_e     state;
   logic [1:0] req_vec;
   logic       accept;
   logic       win;
   op_e        win_op;
   logic       win_reg;
   logic [7:0] win_wdata;

   assign req_vec = {i_req_1, i_req_0};
   assign accept  = (state == ST_IDLE) && (|req_vec);

   rr_arb2 u_arb (
`ifdef REGSET_ARB_ROUNDROBIN_EN
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .advance (accept),
`endif
      .req     (req_vec),
      .win     (win)
   );

   assign win_op    = op_e'(win ? i_op_1 : i_op_0);
   assign win_reg   = win ? i_reg_1 : i_reg_0;
   assign win_wdata = win ? i_wdata_1 : i_wdata_0;
   assign o_busy    = (state != ST_IDLE);

   // Outputs are registered: each state's drive values are loaded on the edge entering it
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state    <= ST_IDLE;
         o_owner  <= 1'b0;
         o_d      <= 8'h00;
         o_write0 <= 1'b0;
         o_write1 <= 1'b0;
         o_busSel <= 1'b0;
         o_busEn  <= 1'b0;
         o_gnt_0  <= 1'b0;
         o_gnt_1  <= 1'b0;
      end else begin
         o_d      <= 8'h00;
         o_write0 <= 1'b0;
         o_write1 <= 1'b0;
         o_busEn  <= 1'b0;
         o_gnt_0  <= 1'b0;
         o_gnt_1  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  o_owner <= win;
                  if (win_op == OP_WRITE) begin
                     state    <= ST_WR;
                     o_write0 <= ~win_reg;
                     o_write1 <= win_reg;
                     o_d      <= win_wdata;
                     o_gnt_0  <= ~win;
                     o_gnt_1  <= win;
                  end else begin
                     state    <= ST_TURN;
                     o_busSel <= win_reg;
                  end
               end
            end
            ST_WR: begin
               state <= ST_IDLE;
            end
            ST_TURN: begin
               state   <= ST_DRV;
               o_busEn <= 1'b1;
               o_gnt_0 <= ~o_owner;
               o_gnt_1 <= o_owner;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regset_arb.sv
// tb/tb_regset_arb.sv - directed self-checking bench for regset_arb
module tb_regset_arb;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_req_0, i_op_0, i_reg_0;
   logic [7:0] i_wdata_0;
   logic       i_req_1, i_op_1, i_reg_1;
   logic [7:0] i_wdata_1;
   logic       o_gnt_0, o_gnt_1;
   logic [7:0] o_d;
   logic       o_write0, o_write1, o_busSel, o_busEn, o_busy, o_owner;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 i_clk = ~i_clk;

   regset_arb dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_req_0   (i_req_0),
      .i_op_0    (i_op_0),
      .i_reg_0   (i_reg_0),
      .i_wdata_0 (i_wdata_0),
      .o_gnt_0   (o_gnt_0),
      .i_req_1   (i_req_1),
      .i_op_1    (i_op_1),
      .i_reg_1   (i_reg_1),
      .i_wdata_1 (i_wdata_1),
      .o_gnt_1   (o_gnt_1),
      .o_d       (o_d),
      .o_write0  (o_write0),
      .o_write1  (o_write1),
      .o_busSel  (o_busSel),
      .o_busEn   (o_busEn),
      .o_busy    (o_busy),
      .o_owner   (o_owner)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bundle of all outputs: {gnt1,gnt0,write1,write0,busSel,busEn,busy,owner}
   function automatic logic [7:0] ctl();
      return {o_gnt_1, o_gnt_0, o_write1, o_write0, o_busSel, o_busEn, o_busy, o_owner};
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b0;
      tick();
      tick();
      i_reset = 1'b1;
   endtask

   initial begin
      i_reset = 1'b0;
      i_req_0 = 0; i_op_0 = 0; i_reg_0 = 0; i_wdata_0 = 8'h00;
      i_req_1 = 0; i_op_1 = 0; i_reg_1 = 0; i_wdata_1 = 8'h00;
      tick();
      chk("reset_ctl", ctl(), 8'h00);
      chk("reset_d", o_d, 8'h00);
      tick();
      i_reset = 1'b1;

      // single WRITE r1 from requester 0
      i_req_0 = 1; i_op_0 = 1; i_reg_0 = 1; i_wdata_0 = 8'hA5;
      tick();
      chk("wr_ctl", ctl(), 8'b0110_0010);
      chk("wr_d", o_d, 8'hA5);
      i_req_0 = 0;
      tick();
      chk("wr_idle_ctl", ctl(), 8'b0000_0000);
      chk("wr_idle_d", o_d, 8'h00);

      // single READ r0 from requester 1
      i_req_1 = 1; i_op_1 = 0; i_reg_1 = 0;
      tick();
      chk("rd_turn_ctl", ctl(), 8'b0000_0011);
      tick();
      chk("rd_drv_ctl", ctl(), 8'b1000_0111);
      i_req_1 = 0;
      tick();
      chk("rd_idle_ctl", ctl(), 8'b0000_0001);

      // idle requester fields ignored when its request is low
      i_op_1 = 1; i_reg_1 = 1; i_wdata_1 = 8'hFF;
      tick();
      chk("ignore_ctl", ctl(), 8'b0000_0001);

      // both requesting WRITEs continuously
      do_reset();
      i_req_0 = 1; i_op_0 = 1; i_reg_0 = 0; i_wdata_0 = 8'h11;
      i_req_1 = 1; i_op_1 = 1; i_reg_1 = 1; i_wdata_1 = 8'h22;
      for (int i = 0; i < 4; i++) begin
         tick();
`ifdef REGSET_ARB_ROUNDROBIN_EN
         if (i % 2 == 0) begin
            chk("both_gnt", ctl(), 8'b0101_0010);
            chk("both_d", o_d, 8'h11);
         end else begin
            chk("both_gnt", ctl(), 8'b1010_0011);
            chk("both_d", o_d, 8'h22);
         end
`else
         chk("both_gnt", ctl(), 8'b0101_0010);
         chk("both_d", o_d, 8'h11);
`endif
         tick();
         chk("both_gap", {o_gnt_1, o_gnt_0, o_write1, o_write0, o_busy}, 8'h00);
      end
      i_req_0 = 0; i_req_1 = 0;

      // READ r1 (req0) and WRITE r1 (req1) together: read first, no overlap
      do_reset();
      i_req_0 = 1; i_op_0 = 0; i_reg_0 = 1;
      i_req_1 = 1; i_op_1 = 1; i_reg_1 = 1; i_wdata_1 = 8'h3C;
      tick();
      chk("rw_turn", ctl(), 8'b0000_1010);
      tick();
      chk("rw_drv", ctl(), 8'b0100_1110);
      i_req_0 = 0;
      tick();
      chk("rw_idle", ctl(), 8'b0000_1000);
      tick();
      chk("rw_wr", ctl(), 8'b1010_1011);
      chk("rw_wr_d", o_d, 8'h3C);
      i_req_1 = 0;
      tick();
      chk("rw_done", ctl(), 8'b0000_1001);

      // reset during TURN aborts the read
      i_req_0 = 1; i_op_0 = 0; i_reg_0 = 1;
      tick();
      chk("rst_turn", ctl(), 8'b0000_1010);
      i_reset = 1'b0;
      i_req_0 = 0;
      #1;
      chk("rst_async", ctl(), 8'h00);
      tick();
      chk("rst_hold", ctl(), 8'h00);
      i_reset = 1'b1;
      i_req_1 = 1; i_op_1 = 1; i_reg_1 = 0; i_wdata_1 = 8'h5A;
      tick();
      chk("rst_after_wr", ctl(), 8'b1001_0011);
      chk("rst_after_d", o_d, 8'h5A);
      i_req_1 = 0;
      tick();
      chk("rst_after_idle", ctl(), 8'b0000_0001);

      // request dropped one cycle after acceptance still completes
      i_req_0 = 1; i_op_0 = 0; i_reg_0 = 1;
      tick();
      chk("drop_turn", ctl(), 8'b0000_1010);
      i_req_0 = 0;
      tick();
      chk("drop_drv", ctl(), 8'b0100_1110);
      tick();
      chk("drop_idle", ctl(), 8'b0000_1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regset_arb.md
REGSET_ARB -- requirements
Module: regset_arb

Interface
REQ-001 SHALL have ports: i_clk  in  1  rising-edge clock; all state updates on this edge.
REQ-002 SHALL have ports: i_reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have per requester k in {0,1}: i_req_k  in  1  request valid, held until grant.
REQ-004 SHALL have per requester k: i_op_k  in  1  operation (0 = READ to bus, 1 = WRITE from data).
REQ-005 SHALL have per requester k: i_reg_k  in  1  target register (0 = r0, 1 = r1).
REQ-006 SHALL have per requester k: i_wdata_k  in  8  write data, WRITE only.
REQ-007 SHALL have per requester k: o_gnt_k  out  1  one-cycle completion pulse.
REQ-008 SHALL drive the register set through: o_d  out  8; o_write0  out  1; o_write1  out  1; o_busSel  out  1; o_busEn  out  1.
REQ-009 SHALL have status outputs: o_busy  out  1  (state != IDLE); o_owner  out  1  (requester being served).

Function
REQ-010 SHALL implement FSM states IDLE, WR, TURN, DRV.
REQ-011 SHALL, in IDLE with any request, select one winner, latch its op, reg and wdata, and go to WR (WRITE) or TURN (READ).
REQ-012 SHALL, in WR, assert exactly one of o_write0/o_write1 per latched reg, drive o_d = latched wdata, pulse o_gnt of the owner, then return to IDLE.
REQ-013 SHALL, in TURN, drive o_busSel = latched reg with o_busEn = 0 (bus turnaround cycle), then go to DRV.
REQ-014 SHALL, in DRV, assert o_busEn = 1 with o_busSel held, pulse o_gnt of the owner, then return to IDLE.
REQ-015 SHALL produce WRITE grant 1 cycle after the IDLE acceptance cycle, and READ grant 2 cycles after it.
REQ-016 SHALL return to IDLE after every transaction, giving at most one transaction per 2 cycles (WRITE) or 3 cycles (READ).
REQ-017 SHALL complete a latched transaction even if its i_req_k drops before grant.
REQ-018 SHALL never assert o_busEn outside DRV, never assert o_write0 or o_write1 outside WR, and never assert both write strobes together.
REQ-019 SHALL serialize simultaneous requests, including a READ and a WRITE to the same register; the order is set by arbitration only.
REQ-020 SHALL hold o_d at 0 outside WR.
REQ-021 SHALL hold o_busSel at its last value outside TURN/DRV.
REQ-022 SHALL ignore i_op/i_reg/i_wdata of a requester whose i_req_k is low.

Reset
REQ-023 SHALL, on i_reset low, immediately enter IDLE with all outputs 0, including o_owner and both o_gnt.
REQ-024 SHALL set the round-robin pointer at reset so that requester 0 wins the first contended arbitration.
REQ-025 SHALL abort a transaction interrupted by reset without a write strobe or grant; the requester re-requests.

Configuration
REQ-026 SHALL support macro REGSET_ARB_ROUNDROBIN_EN.
REQ-027 SHALL, with REGSET_ARB_ROUNDROBIN_EN defined, grant the requester not served last when both request in IDLE.
REQ-028 SHALL, without REGSET_ARB_ROUNDROBIN_EN, use fixed priority with requester 0 always winning, and remove the pointer flop.
REQ-029 SHALL behave identically in both configurations when only one requester is active.

Structure
REQ-030 SHALL place the op enum (READ/WRITE) and the FSM state enum in shared package regset_pkg.
REQ-031 SHALL implement winner selection in sub-module rr_arb2 (2-way arbiter with pointer update on grant), instantiated once.

Verification
REQ-032 SHALL cover: single WRITE, req0 op=1 reg=1 wdata=0xA5 -> o_write1=1, o_d=0xA5, and o_gnt_0 in the cycle after acceptance, with o_busEn=0 throughout.
REQ-033 SHALL cover: single READ, req1 op=0 reg=0 -> TURN cycle with busSel=0 and busEn=0, then DRV with busEn=1 and o_gnt_1, 2 cycles after acceptance.
REQ-034 SHALL cover: both requesting continuously, WRITE each, RR enabled -> grants alternate 0,1,0,1 at one per 2 cycles; RR disabled -> only requester 0 is granted.
REQ-035 SHALL cover: req0 READ r1 and req1 WRITE r1=0x3C together -> READ completes (busEn) before write1 asserts; the two never overlap.
REQ-036 SHALL cover: reset asserted during TURN -> outputs 0 immediately, no busEn or gnt, next request served from IDLE normally.
REQ-037 SHALL cover: i_req_0 dropped one cycle after acceptance -> transaction still completes with o_gnt_0.
